muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit for the single-issue core.
- Sits beside the ALU in execute and feeds the writeback result mux as one of its mux inputs.
- Controller accepts one operation per start pulse, holds the pipeline via busy, and presents a registered result with a one-cycle done pulse.
- One radix-2 step per clock: shift-add for multiply, restoring for divide.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_unit.sv | 137 +++++++++++++
 tb/tb_muldiv_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_SIGN = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply and
// restoring divide are both computed; the caller keeps the one it needs.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int bits = 32
) (
   input  logic [2*bits-1:0] prod_in,
   input  logic [bits-1:0]   rem_in,
   input  logic [bits-1:0]   quo_in,
   input  logic [bits-1:0]   operand,
   output logic [2*bits-1:0] prod_out,
   output logic [bits-1:0]   rem_out,
   output logic [bits-1:0]   quo_out
);

   logic [bits:0] sum;
   logic [bits:0] shifted;
   logic [bits:0] diff;

   // Multiply: add multiplicand on LSB of the multiplier, then shift right.
   // Divide: shift in the next dividend bit and keep the difference if it is non-negative.
   always_comb begin
      sum      = {1'b0, prod_in[2*bits-1:bits]} + (prod_in[0] ? {1'b0, operand} : {(bits+1){1'b0}});
      prod_out = {sum, prod_in[bits-1:1]};
      shifted  = {rem_in, quo_in[bits-1]};
      diff     = shifted - {1'b0, operand};
      if (!diff[bits]) begin
         rem_out = diff[bits-1:0];
         quo_out = {quo_in[bits-2:0], 1'b1};
      end else begin
         rem_out = shifted[bits-1:0];
         quo_out = {quo_in[bits-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the ALU.
//
// state  | meaning
// IDLE   | waiting for start; result held
// CALC   | one radix-2 step per clock, bits cycles
// SIGN   | apply sign correction, load result
// DONE   | done pulse for one cycle
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int bits = 32
) (
   input  logic            clk,
   input  logic            async_reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [bits-1:0] rs1_val,
   input  logic [bits-1:0] rs2_val,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [bits-1:0] result
);

   localparam int cnt_width = $clog2(bits) + 1;
   localparam logic [cnt_width-1:0] last_count = cnt_width'(bits - 1);
   localparam logic [bits-1:0] min_val = {1'b1, {(bits-1){1'b0}}};

   state_t state, state_nxt;
   logic                 accept;
   logic [2:0]           op;
   logic                 neg;
   logic [cnt_width-1:0] count;
   logic [2*bits-1:0]    prod, prod_step, prod_signed;
   logic [bits-1:0]      rem, quo, operand, rem_step, quo_step;
   logic [bits-1:0]      quo_signed, rem_signed, sel;
   logic                 sign_a, sign_b, div_zero, overflow, special;
   logic [bits-1:0]      abs_a, abs_b, special_val;

   muldiv_step #(.bits(bits)) u_step (
      .prod_in  (prod),
      .rem_in   (rem),
      .quo_in   (quo),
      .operand  (operand),
      .prod_out (prod_step),
      .rem_out  (rem_step),
      .quo_out  (quo_step)
   );

   // Operand decode at launch: sign flags, magnitudes and the early-out results.
   always_comb begin
      sign_a   = !(funct3 inside {F3_MULHU, F3_DIVU, F3_REMU}) && rs1_val[bits-1];
      sign_b   = (funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM}) && rs2_val[bits-1];
      abs_a    = sign_a ? -rs1_val : rs1_val;
      abs_b    = sign_b ? -rs2_val : rs2_val;
      div_zero = funct3[2] && (rs2_val == '0);
      overflow = funct3[2] && !funct3[0] && (rs1_val == min_val) && (rs2_val == '1);
      special  = div_zero || overflow;
      if (div_zero) special_val = funct3[1] ? rs1_val : '1;
      else          special_val = funct3[1] ? '0 : min_val;
   end

   // Sign correction and output selection for the SIGN cycle.
   always_comb begin
      prod_signed = neg ? -prod : prod;
      quo_signed  = neg ? -quo : quo;
      rem_signed  = neg ? -rem : rem;
      sel         = prod_signed[bits-1:0];
      case (op)
         F3_MULH, F3_MULHSU, F3_MULHU: sel = prod_signed[2*bits-1:bits];
         F3_DIV, F3_DIVU:              sel = quo_signed;
         F3_REM, F3_REMU:              sel = rem_signed;
         default:                      sel = prod_signed[bits-1:0];
      endcase
   end

   // Next-state logic; flush always wins over start and over progress.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !flush) begin
               accept    = 1'b1;
               state_nxt = special ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (flush)                    state_nxt = S_IDLE;
            else if (count == last_count) state_nxt = S_SIGN;
         end
         S_SIGN:  state_nxt = flush ? S_IDLE : S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) state <= S_IDLE;
      else             state <= state_nxt;
   end

   // Datapath: capture on launch, iterate in CALC, load result on SIGN or early-out.
   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         op      <= '0;
         neg     <= 1'b0;
         count   <= '0;
         prod    <= '0;
         rem     <= '0;
         quo     <= '0;
         operand <= '0;
         result  <= '0;
      end else if (accept) begin
         op      <= funct3;
         neg     <= (funct3[2] && funct3[1]) ? sign_a : (sign_a ^ sign_b);
         count   <= '0;
         prod    <= {{bits{1'b0}}, abs_b};
         rem     <= '0;
         quo     <= abs_a;
         operand <= funct3[2] ? abs_b : abs_a;
         if (special) result <= special_val;
      end else if (state == S_CALC) begin
         prod  <= prod_step;
         rem   <= rem_step;
         quo   <= quo_step;
         count <= count + 1'b1;
      end else if (state == S_SIGN && !flush) begin
         result <= sel;
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// compared against a plain-arithmetic RV32M reference.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        async_reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] rs1_val = '0;
   logic [31:0] rs2_val = '0;
   logic        flush = 1'b0;
   logic        busy, done;
   logic [31:0] result;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] last_res = '0;

   muldiv_unit #(.bits(32)) dut (
      .clk         (clk),
      .async_reset (async_reset),
      .start       (start),
      .funct3      (funct3),
      .rs1_val     (rs1_val),
      .rs2_val     (rs2_val),
      .flush       (flush),
      .busy        (busy),
      .done        (done),
      .result      (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'b0, a};
      ub = {32'b0, b};
      p  = '0;
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic bit early_out(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   // Launch one op at cycle 0; optional extra starts (xs1/xs2) and a flush cycle (fl), -1 = none.
   task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int xs1, input int xs2, input int fl);
      logic [31:0] exp_res, res_at_done;
      int exp_lat, last_busy, done_cnt, done_cyc, busy_err;
      bit exp_busy;
      exp_lat   = early_out(f3, a, b) ? 1 : 34;
      last_busy = (fl >= 0) ? fl : exp_lat;
      exp_res   = (fl >= 0) ? last_res : model(f3, a, b);
      done_cnt  = 0;
      done_cyc  = -1;
      busy_err  = 0;
      res_at_done = '0;
      @(negedge clk);
      start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         start   = (cyc == xs1 || cyc == xs2) && (cyc <= last_busy);
         flush   = (cyc == fl);
         rs1_val = $urandom;
         rs2_val = $urandom;
         if (done) begin
            done_cnt++;
            done_cyc    = cyc;
            res_at_done = result;
         end
         exp_busy = (cyc <= last_busy);
         if (busy !== exp_busy) busy_err++;
      end
      start = 1'b0;
      flush = 1'b0;
      chk({tag, " busy_window"}, busy_err, 0);
      if (fl >= 0) begin
         chk({tag, " done_count"}, done_cnt, 0);
      end else begin
         chk({tag, " done_count"}, done_cnt, 1);
         chk({tag, " done_cycle"}, done_cyc, exp_lat);
         chk({tag, " result_at_done"}, res_at_done, exp_res);
      end
      chk({tag, " result_held"}, result, exp_res);
      last_res = exp_res;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset result", result, 0);
      @(negedge clk);
      async_reset = 1'b0;

      do_op("mul_neg", 3'd0, 32'd7, 32'hFFFF_FFFD, -1, -1, -1);
      do_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, -1, -1, -1);
      do_op("mulhu_ones", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
      do_op("mulhsu_ones", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
      do_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, -1, -1, -1);
      do_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, -1, -1, -1);
      do_op("divu", 3'd5, 32'd100, 32'd7, -1, -1, -1);
      do_op("remu", 3'd7, 32'd100, 32'd7, -1, -1, -1);
      do_op("divu_zero", 3'd5, 32'd5, 32'd0, -1, -1, -1);
      do_op("rem_zero", 3'd6, 32'd5, 32'd0, -1, -1, -1);
      do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
      do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
      do_op("div_flush", 3'd4, 32'd100, 32'd7, -1, -1, 10);
      do_op("mul_after_flush", 3'd0, 32'd3, 32'd4, -1, -1, -1);
      do_op("start_ignored", 3'd0, 32'd1234, 32'd5678, 5, 34, -1);

      // start and flush together in IDLE launch nothing
      @(negedge clk);
      start = 1'b1; flush = 1'b1; funct3 = 3'd0; rs1_val = 32'd9; rs2_val = 32'd9;
      @(negedge clk);
      chk("start_flush busy", busy, 0);
      start = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("start_flush busy2", busy, 0);
      chk("start_flush done", done, 0);
      chk("start_flush result", result, last_res);

      // asynchronous reset mid-CALC, applied between clock edges
      @(negedge clk);
      start = 1'b1; funct3 = 3'd0; rs1_val = 32'd3; rs2_val = 32'd4;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 async_reset = 1'b1;
      #1;
      chk("async_rst busy", busy, 0);
      chk("async_rst done", done, 0);
      chk("async_rst result", result, 0);
      @(negedge clk);
      async_reset = 1'b0;
      last_res = '0;

      for (int i = 0; i < 40; i++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         int xs;
         f3 = 3'($urandom_range(0, 7));
         a  = pick_operand();
         b  = pick_operand();
         xs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 34)) : -1;
         do_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b, xs, -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
